// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
//   Arbitration is round-robin at packet granularity: once a requester wins,
//   it keeps the grant until it sends a byte flagged req_last (or a frame
//   start times out). Each byte is captured in one cycle and presented on
//   tx_data/parity_mode, which stay stable until the serializer finishes.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   req_valid/data/last     per-requester byte stream (valid held until ready)
//   req_ready               one-hot, one-cycle byte-accept pulse
//   cfg_parity              per-requester parity mode, 2 bits each
//   tx_start/data           start request and byte to uart_tx
//   parity_mode             parity mode to uart_tx
//   tx_busy                 busy flag from uart_tx
//   grant_id                current/last granted requester
//   arb_busy                high whenever the arbiter is not idle
//   err_timeout             one-cycle pulse when tx_busy never answers tx_start
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 0,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   cfg_parity,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [1:0]             parity_mode,
  input  logic                   tx_busy,
  output logic [GW-1:0]          grant_id,
  output logic                   arb_busy,
  output logic                   err_timeout
);

  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int GCW = $clog2(GAP_CYC + 2);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAPTURE   = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  rr_ptr;
  logic           locked;
  logic           last_r;
  logic           seen_low;
  logic [TCW-1:0] tmo_cnt;
  logic [GCW-1:0] gap_cnt;

  logic [7:0]     data_arr [NUM_REQ];
  logic [1:0]     par_arr  [NUM_REQ];
  logic [GW-1:0]  cand;
  logic [GW-1:0]  rr_pick;
  logic           rr_hit;
  logic [GW-1:0]  grant_inc;
  logic           do_grant, do_capture, do_timeout, do_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
    assign par_arr[g]  = cfg_parity[2*g +: 2];
  end

  assign grant_inc = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Round-robin pick: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    rr_hit  = 1'b0;
    rr_pick = rr_ptr;
    cand    = rr_ptr;
    // Scanning from the far end means the nearest offset is the last writer.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        rr_hit  = 1'b1;
        rr_pick = cand;
      end
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    do_done    = 1'b0;
    req_ready  = '0;
    tx_start   = 1'b0;
    arb_busy   = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (locked) begin
          if (req_valid[grant_id]) state_nxt = S_CAPTURE;
        end else if (rr_hit) begin
          do_grant  = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        req_ready[grant_id] = 1'b1;
        do_capture          = 1'b1;
        state_nxt           = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        // Busy only counts as acceptance after it has been seen low, so a
        // serializer still finishing an earlier frame is not mistaken for ours.
        if (tx_busy && seen_low) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          do_done   = 1'b1;
          state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      locked      <= 1'b0;
      last_r      <= 1'b0;
      tx_data     <= '0;
      parity_mode <= '0;
      err_timeout <= 1'b0;
      seen_low    <= 1'b0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      err_timeout <= do_timeout;

      if (do_grant) grant_id <= rr_pick;

      // tx_data/parity_mode change only here, so they hold through the frame.
      if (do_capture) begin
        tx_data     <= data_arr[grant_id];
        parity_mode <= par_arr[grant_id];
        last_r      <= req_last[grant_id];
      end

      // Counters and the seen-low flag restart on every entry to their state.
      if (state == S_START) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (!tx_busy) seen_low <= 1'b1;
      end else begin
        tmo_cnt  <= '0;
        seen_low <= 1'b0;
      end

      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;

      // A dropped byte releases the lock so one stuck stream cannot starve others.
      if (do_timeout) begin
        locked <= 1'b0;
        rr_ptr <= grant_inc;
      end

      if (do_done) begin
        if (last_r) begin
          locked <= 1'b0;
          rr_ptr <= grant_inc;
        end else begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester FIFOs with optional
// post-byte pause, a behavioural uart_tx that logs each frame, and
// hand-derived expectations per scenario.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int GAP_CYC     = 5;
  localparam int GW          = 2;
  localparam int LAT         = 2;   // serializer: cycles from tx_start seen to busy rise
  localparam int LEN         = 10;  // serializer: cycles busy stays high

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_REQ-1:0]   req_valid, req_last, req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0] cfg_parity = '0;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [1:0]           parity_mode;
  logic                 tx_busy;
  logic [GW-1:0]        grant_id;
  logic                 arb_busy, err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .cfg_parity  (cfg_parity),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .parity_mode (parity_mode),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- requesters: per-requester byte FIFOs ----------------
  logic [7:0] rq_byte [NUM_REQ][16];
  logic       rq_last [NUM_REQ][16];
  logic [3:0] wr [NUM_REQ];
  logic [3:0] rd [NUM_REQ];
  int         pause_after [NUM_REQ];
  int         pause_cnt   [NUM_REQ];
  int         xfer_cnt    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_valid[g]       = (rd[g] != wr[g]) && (pause_cnt[g] == 0);
    assign req_data[8*g +: 8] = rq_byte[g][rd[g]];
    assign req_last[g]        = rq_last[g][rd[g]];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rd[i]        <= wr[i];
        pause_cnt[i] <= 0;
        xfer_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          rd[i]        <= rd[i] + 1'b1;
          pause_cnt[i] <= pause_after[i];
          xfer_cnt[i]  <= xfer_cnt[i] + 1;
        end else if (pause_cnt[i] != 0) begin
          pause_cnt[i] <= pause_cnt[i] - 1;
        end
      end
    end
  end

  // ---------------- behavioural serializer ----------------
  logic       model_en;
  int         m_phase, m_cnt, frame_cnt;
  logic [7:0] frame_byte [16];
  logic [1:0] frame_par  [16];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy   <= 1'b0;
      m_phase   <= 0;
      m_cnt     <= 0;
      frame_cnt <= 0;
    end else begin
      case (m_phase)
        0: if (tx_start && model_en) begin
          m_phase <= 1;
          m_cnt   <= 0;
        end
        1: if (m_cnt == LAT - 1) begin
          tx_busy                  <= 1'b1;
          m_phase                  <= 2;
          m_cnt                    <= 0;
          frame_byte[frame_cnt%16] <= tx_data;
          frame_par[frame_cnt%16]  <= parity_mode;
          frame_cnt                <= frame_cnt + 1;
        end else m_cnt <= m_cnt + 1;
        default: if (m_cnt == LEN - 1) begin
          tx_busy <= 1'b0;
          m_phase <= 0;
        end else m_cnt <= m_cnt + 1;
      endcase
    end
  end

  // Byte and parity must be unchanged on the last busy cycle of every frame.
  always @(negedge clk) begin
    if (!reset && m_phase == 2 && m_cnt == LEN - 1)
      check("frame_hold", {tx_data, parity_mode},
            {frame_byte[(frame_cnt-1)%16], frame_par[(frame_cnt-1)%16]});
  end

  // ---------------- monitors ----------------
  int   cyc = 0, start_cycles = 0, err_cycles = 0, fall_cyc = 0, cap_cyc = 0;
  logic busy_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_d <= tx_busy;
    if (tx_start)            start_cycles <= start_cycles + 1;
    if (err_timeout)         err_cycles   <= err_cycles + 1;
    if (busy_d && !tx_busy)  fall_cyc     <= cyc;
    if (|req_ready)          cap_cyc      <= cyc;
  end

  // ---------------- helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq_byte[r][wr[r]] = d;
    rq_last[r][wr[r]] = l;
    wr[r] = wr[r] + 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k;
    k = 0;
    while (frame_cnt < n && k < 2000) begin
      step(1);
      k++;
    end
    check(tag, frame_cnt, n);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((arb_busy || tx_busy) && k < 2000) begin
      step(1);
      k++;
    end
    check(tag, {arb_busy, tx_busy}, 2'b00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    int s0, e0, k;
    model_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr[i]          = '0;
      pause_after[i] = 0;
    end
    #1 reset = 1'b1;
    step(2);

    // Reset state.
    check("rst_ready",  req_ready,   4'b0000);
    check("rst_start",  tx_start,    1'b0);
    check("rst_data",   tx_data,     8'h00);
    check("rst_par",    parity_mode, 2'b00);
    check("rst_grant",  grant_id,    2'd0);
    check("rst_busy",   arb_busy,    1'b0);
    check("rst_err",    err_timeout, 1'b0);
    reset = 1'b0;
    step(1);

    // Single byte: valid -> CAPTURE next cycle, tx_start the cycle after.
    cfg_parity = 8'b00_00_00_01;
    push(0, 8'h55, 1'b1);
    step(1);
    check("t1_ready",       req_ready, 4'b0001);
    check("t1_start_early", tx_start,  1'b0);
    step(1);
    check("t1_start",       tx_start,    1'b1);
    check("t1_data",        tx_data,     8'h55);
    check("t1_par",         parity_mode, 2'b01);
    check("t1_ready_once",  req_ready,   4'b0000);
    wait_frames(1, "t1_frames");
    wait_idle("t1_idle");
    check("t1_xfer",        xfer_cnt[0],   1);
    check("t1_frame",       frame_byte[0], 8'h55);
    // rr_ptr is now 1, so requester 1 beats requester 0.
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    wait_frames(3, "t1b_frames");
    wait_idle("t1b_idle");
    check("t1_rr_first",  frame_byte[1], 8'h22);
    check("t1_rr_second", frame_byte[2], 8'h11);

    // Round-robin: all four valid, requester 0 has a second packet.
    do_reset();
    cfg_parity = '0;
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA4, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1);
    wait_frames(5, "t2_frames");
    wait_idle("t2_idle");
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_order%0d", i), frame_byte[i], 8'hA0 + 8'(i));
    check("t2_xfer0", xfer_cnt[0], 2);
    check("t2_xfer3", xfer_cnt[3], 1);

    // Packet lock: requester 1 pauses 50 cycles between bytes, requester 2 waits.
    do_reset();
    pause_after[1] = 50;
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    push(2, 8'hC0, 1'b1);
    wait_frames(1, "t3_first");
    step(30);
    check("t3_hold_frames", frame_cnt,   1);
    check("t3_hold_grant",  grant_id,    2'd1);
    check("t3_hold_idle",   arb_busy,    1'b0);
    check("t3_hold_req2",   xfer_cnt[2], 0);
    wait_frames(4, "t3_frames");
    wait_idle("t3_idle");
    check("t3_order0", frame_byte[0], 8'hB1);
    check("t3_order1", frame_byte[1], 8'hB2);
    check("t3_order2", frame_byte[2], 8'hB3);
    check("t3_order3", frame_byte[3], 8'hC0);
    pause_after[1] = 0;

    // Timeout: serializer silent, tx_start held exactly TIMEOUT_CYC cycles.
    do_reset();
    model_en = 1'b0;
    s0 = start_cycles;
    e0 = err_cycles;
    push(0, 8'hD0, 1'b0);
    push(0, 8'hD2, 1'b1);
    push(1, 8'hD1, 1'b1);
    k = 0;
    while (!err_timeout && k < 400) begin
      step(1);
      k++;
    end
    check("t4_err_seen",  err_timeout,       1'b1);
    check("t4_start_len", start_cycles - s0, TIMEOUT_CYC);
    model_en = 1'b1;
    step(1);
    // Lock cleared and rr_ptr advanced: requester 1 wins over requester 0.
    check("t4_regrant",   grant_id,  2'd1);
    check("t4_ready",     req_ready, 4'b0010);
    wait_frames(2, "t4_frames");
    wait_idle("t4_idle");
    check("t4_order0",    frame_byte[0],   8'hD1);
    check("t4_order1",    frame_byte[1],   8'hD2);
    check("t4_err_width", err_cycles - e0, 1);

    // Gap and parity: req0 parity 10, req1 parity 00, req0 cfg changed mid-frame.
    do_reset();
    cfg_parity = 8'b00_00_00_10;
    push(0, 8'hE0, 1'b1);
    push(1, 8'hE1, 1'b1);
    step(2);
    check("t5_par_start", parity_mode, 2'b10);
    cfg_parity[1:0] = 2'b01;
    wait_frames(1, "t5_first");
    k = 0;
    while (tx_busy && k < 100) begin
      step(1);
      k++;
    end
    step(2);
    check("t5_gap_busy",  arb_busy,    1'b1);
    check("t5_gap_par",   parity_mode, 2'b10);
    check("t5_gap_ready", req_ready,   4'b0000);
    wait_frames(2, "t5_frames");
    // Busy-low cycle in WAIT_DONE + 5 GAP + 1 IDLE puts CAPTURE 7 cycles later.
    check("t5_gap_len",   cap_cyc - fall_cyc, 7);
    check("t5_par0",      frame_par[0],  2'b10);
    check("t5_par1",      frame_par[1],  2'b00);
    check("t5_order1",    frame_byte[1], 8'hE1);
    wait_idle("t5_idle");

    // Reset during WAIT_DONE, after rr_ptr had moved to 3.
    do_reset();
    cfg_parity = 8'b00_01_00_00;
    push(2, 8'hF0, 1'b1);
    push(2, 8'hF1, 1'b1);
    wait_frames(2, "t6_frames");
    step(3);
    check("t6_pre_grant", grant_id, 2'd2);
    check("t6_pre_busy",  arb_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_ready", req_ready,   4'b0000);
    check("t6_rst_start", tx_start,    1'b0);
    check("t6_rst_data",  tx_data,     8'h00);
    check("t6_rst_par",   parity_mode, 2'b00);
    check("t6_rst_grant", grant_id,    2'd0);
    check("t6_rst_busy",  arb_busy,    1'b0);
    check("t6_rst_err",   err_timeout, 1'b0);
    step(2);
    reset = 1'b0;
    step(1);
    cfg_parity = '0;
    push(3, 8'h33, 1'b1);
    push(1, 8'h31, 1'b1);
    wait_frames(2, "t6_after_frames");
    wait_idle("t6_idle");
    check("t6_order0", frame_byte[0], 8'h31);
    check("t6_order1", frame_byte[1], 8'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
